// File: rtl/fp16_pkg.sv
// Shared FP16 field layout and arbiter FSM encoding.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package fp16_pkg;

  localparam int FP16_W = 16;
  localparam int EXP_W  = 5;
  localparam int MAN_W  = 10;

  // Field positions inside an FP16 word
  localparam int SIGN_BIT = 15;
  localparam int EXP_HI   = 14;
  localparam int EXP_LO   = 10;
  localparam int MAN_HI   = 9;
  localparam int MAN_LO   = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first valid requester at or above rr_ptr, wrapping past NREQ-1.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is accepted.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [IDW-1:0]  winner,
  output logic            any_valid
);

  int idx;

  // Scan requesters starting at the pointer; the first valid one wins
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!any_valid && valid[idx]) begin
        winner    = IDW'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp16_mul_arbiter.sv
// Round-robin sharing of one external combinational FP16 multiplier among NREQ clients.
// Latency: grant edge to res_valid is 2 cycles; at most one result every 2 cycles.
// Backpressure: res_ready low holds the result and blocks all grants until accepted.
module fp16_mul_arbiter
  import fp16_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int IDW  = 2,
  localparam int W    = FP16_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W-1:0]      res_data,
  output logic [IDW-1:0]    res_id,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic [W-1:0]      mul_p
);

  arb_state_t     state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] op_id;
  logic [W-1:0]   op_a, op_b;
  logic           any_valid;
  logic           accept_ok;
  logic           grant;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .valid     (req_valid),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // A new operation can start when idle, or when the held result leaves this cycle.
  // Gating with rst_n keeps every ready low while the block is held in reset.
  assign accept_ok = (state == IDLE) || ((state == RESP) && res_ready);
  assign grant     = accept_ok && any_valid && rst_n;

  // Operand registers feed the multiplier directly, so its inputs stay stable through ISSUE
  assign mul_a     = op_a;
  assign mul_b     = op_b;
  assign res_valid = (state == RESP);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and one-hot grant decode
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE:    if (grant) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    if (res_ready) state_nxt = grant ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (grant) req_ready[winner] = 1'b1;
  end

  // Operand capture on grant, pointer advance, and product capture at the end of ISSUE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_id    <= '0;
      res_data <= '0;
      res_id   <= '0;
    end else begin
      if (grant) begin
        op_a   <= req_a[int'(winner)*W +: W];
        op_b   <= req_b[int'(winner)*W +: W];
        op_id  <= winner;
        rr_ptr <= IDW'((int'(winner) + 1) % NREQ);
      end
      if (state == ISSUE) begin
        res_data <= mul_p;
        res_id   <= op_id;
      end
    end
  end

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
module tb_fp16_mul_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*16-1:0] req_a, req_b;
  logic              res_valid;
  logic              res_ready;
  logic [15:0]       res_data;
  logic [IDW-1:0]    res_id;
  logic [15:0]       mul_a, mul_b, mul_p;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Stand-in multiplier: exact FP16 products for the named vectors, a scramble otherwise
  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h3C00_3C00: return 16'h3C00;   // 1.0 * 1.0
      32'h4000_4200: return 16'h4600;   // 2.0 * 3.0 = 6.0
      32'hC000_3800: return 16'hBC00;   // -2.0 * 0.5 = -1.0
      32'hC500_0000: return 16'h8000;   // -5.0 * +0 = -0
      default:       return a ^ {b[7:0], b[15:8]} ^ 16'h5A5A;
    endcase
  endfunction

  assign mul_p = fmul(mul_a, mul_b);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp16_mul_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-requester operation queues, {a,b}
  logic [31:0] opq [NREQ][16];
  int qh [NREQ];
  int qt [NREQ];

  task automatic push(input int r, input logic [15:0] a, input logic [15:0] b);
    opq[r][qt[r] % 16] = {a, b};
    qt[r] = qt[r] + 1;
  endtask

  // Requester driver: holds each operation until it is granted, then presents the next
  logic [NREQ-1:0] gnt_seen;
  initial begin
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    forever begin
      @(negedge clk);
      gnt_seen = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_seen[i]) qh[i] = qh[i] + 1;
        req_valid[i] = (qh[i] != qt[i]);
        req_a[i*16 +: 16] = req_valid[i] ? opq[i][qh[i] % 16][31:16] : 16'h0000;
        req_b[i*16 +: 16] = req_valid[i] ? opq[i][qh[i] % 16][15:0]  : 16'h0000;
      end
    end
  end

  // Event logs taken from the DUT for directed checks
  int gnt_n = 0, res_n = 0;
  int gnt_id [64];
  int gnt_cyc [64];
  int res_idl [64];
  int res_dat [64];
  int res_cyc [64];

  // Transaction-level model plus per-cycle comparison
  initial begin : cmp
    int m_ptr, n_ptr, win, m_opid, n_opid, m_rid, n_rid;
    bit m_inf, n_inf, m_rv, n_rv;
    logic [15:0] m_opa, m_opb, m_rd, n_opa, n_opb, n_rd;
    logic [NREQ-1:0] e_rdy;
    m_ptr = 0; m_inf = 0; m_rv = 0; m_opa = 0; m_opb = 0; m_opid = 0; m_rd = 0; m_rid = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_ptr = 0; m_inf = 0; m_rv = 0; m_opa = 0; m_opb = 0; m_opid = 0; m_rd = 0; m_rid = 0;
      end
      win = -1;
      if (rst_n && !m_inf && (!m_rv || res_ready)) begin
        for (int k = 0; k < NREQ; k++) begin
          int j;
          j = (m_ptr + k) % NREQ;
          if (win < 0 && req_valid[j]) win = j;
        end
      end
      e_rdy = (win >= 0) ? NREQ'(1 << win) : '0;
      chk("req_ready", req_ready, e_rdy);
      chk("res_valid", res_valid, m_rv);
      if (m_rv || !rst_n) begin
        chk("res_data", res_data, m_rd);
        chk("res_id", res_id, m_rid);
      end
      chk("mul_a", mul_a, m_opa);
      chk("mul_b", mul_b, m_opb);

      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && gnt_n < 64) begin
          gnt_id[gnt_n] = i; gnt_cyc[gnt_n] = cyc; gnt_n++;
        end
      end
      if (res_valid && res_ready && res_n < 64) begin
        res_idl[res_n] = res_id; res_dat[res_n] = res_data; res_cyc[res_n] = cyc; res_n++;
      end

      n_ptr = m_ptr; n_inf = m_inf; n_rv = m_rv; n_opa = m_opa; n_opb = m_opb;
      n_opid = m_opid; n_rd = m_rd; n_rid = m_rid;
      if (m_inf) begin
        n_rv = 1; n_rd = fmul(m_opa, m_opb); n_rid = m_opid; n_inf = 0;
      end else if (m_rv && res_ready) begin
        n_rv = 0;
      end
      if (win >= 0) begin
        n_opa = req_a[win*16 +: 16]; n_opb = req_b[win*16 +: 16];
        n_opid = win; n_inf = 1; n_ptr = (win + 1) % NREQ;
      end
      @(posedge clk);
      if (rst_n) begin
        m_ptr = n_ptr; m_inf = n_inf; m_rv = n_rv; m_opa = n_opa; m_opb = n_opb;
        m_opid = n_opid; m_rd = n_rd; m_rid = n_rid;
      end
    end
  end

  task automatic wait_res(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (res_n < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    chk(name, (res_n >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : main
    int r0, g0, c;
    for (int i = 0; i < NREQ; i++) begin qh[i] = 0; qt[i] = 0; end
    res_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_mul_a", mul_a, 0);
    rst_n = 1'b1;

    // Single request 1.0 * 1.0
    @(negedge clk);
    push(0, 16'h3C00, 16'h3C00);
    wait_res(1, 20, "t1_timeout");
    chk("t1_id", res_idl[0], 0);
    chk("t1_data", res_dat[0], 32'h3C00);
    chk("t1_latency", res_cyc[0] - gnt_cyc[0], 2);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_idle_res_valid", res_valid, 0);

    // Requests 1 and 3 together; 1 first, 3 back-to-back
    r0 = res_n; g0 = gnt_n;
    @(negedge clk);
    push(1, 16'h4000, 16'h4200);
    push(3, 16'hC000, 16'h3800);
    wait_res(r0 + 2, 30, "t2_timeout");
    chk("t2_id0", res_idl[r0], 1);
    chk("t2_data0", res_dat[r0], 32'h4600);
    chk("t2_id1", res_idl[r0+1], 3);
    chk("t2_data1", res_dat[r0+1], 32'hBC00);
    chk("t2_res_gap", res_cyc[r0+1] - res_cyc[r0], 2);
    chk("t2_gnt_gap", gnt_cyc[g0+1] - gnt_cyc[g0], 2);

    // All four continuously valid: strict rotation, one grant every 2 cycles
    r0 = res_n; g0 = gnt_n;
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NREQ; i++)
        push(i, 16'h1000 + 16'(i * 16'h0111), 16'h2222 + 16'(k));
    wait_res(r0 + 8, 60, "t3_timeout");
    for (int k = 0; k < 8; k++) begin
      chk("t3_order", gnt_id[g0+k], k % 4);
      if (k > 0) chk("t3_gnt_gap", gnt_cyc[g0+k] - gnt_cyc[g0+k-1], 2);
    end

    // Backpressure: result held for several cycles with a request pending
    r0 = res_n;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    push(2, 16'h4000, 16'h4200);
    c = 0;
    while (!res_valid && c < 20) begin @(negedge clk); c++; end
    chk("t4_res_valid_seen", res_valid, 1);
    push(1, 16'h3C00, 16'h3C00);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_hold_data", res_data, 32'h4600);
      chk("t4_hold_id", res_id, 2);
      chk("t4_hold_ready", req_ready, 0);
      chk("t4_hold_valid", res_valid, 1);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("t4_b2b_grant", req_ready, 4'b0010);
    @(posedge clk);
    #1;
    chk("t4_released", res_valid, 0);
    wait_res(r0 + 2, 20, "t4_timeout");
    chk("t4_first_id", res_idl[r0], 2);
    chk("t4_second_id", res_idl[r0+1], 1);
    chk("t4_second_data", res_dat[r0+1], 32'h3C00);

    // Zero operand: sign comes straight from the multiplier
    r0 = res_n;
    @(negedge clk);
    push(0, 16'hC500, 16'h0000);
    wait_res(r0 + 1, 20, "t5_timeout");
    chk("t5_mag_zero", res_dat[r0] & 32'h7FFF, 0);
    chk("t5_sign", res_dat[r0][15], fmul(16'hC500, 16'h0000) >> 15);
    chk("t5_data", res_dat[r0], 32'h8000);

    // Reset during ISSUE discards the operation and restarts the pointer
    r0 = res_n; g0 = gnt_n;
    @(negedge clk);
    push(1, 16'h4000, 16'h4200);
    c = 0;
    while (gnt_n == g0 && c < 20) begin @(posedge clk); c++; end
    chk("t6_grant_seen", (gnt_n > g0) ? 32'd1 : 32'd0, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_res_valid", res_valid, 0);
    chk("t6_rst_req_ready", req_ready, 0);
    chk("t6_rst_mul_a", mul_a, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    chk("t6_no_stale", res_n, r0);
    @(negedge clk);
    push(2, 16'h4400, 16'h3C00);
    push(0, 16'h3800, 16'h3800);
    wait_res(r0 + 2, 30, "t6_timeout");
    chk("t6_first_gnt", gnt_id[g0+1], 0);
    chk("t6_second_gnt", gnt_id[g0+2], 2);
    chk("t6_first_res", res_idl[r0], 0);
    chk("t6_second_res", res_idl[r0+1], 2);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
